// File: rtl/ara_acc_sequencer.sv
// ara_acc_sequencer
//
// Issue/response sequencer between the scalar core's accelerator port and the
// Ara request/response interface. Core instructions go into a small issue FIFO.
// They are forwarded to Ara from the FIFO head while fewer than MAX_OUTSTANDING
// instructions are in flight. Ara responses pass through a one-entry register
// back to the core. A level-sensitive drain handshake lets the core quiesce the
// block for fences and context switches.
//
// Optional feature: define ARA_SEQ_PERF_CNT_EN to add the perf_issued_o and
// perf_stall_o counters. These are 32-bit and wrap.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   core_req_*              core -> sequencer instruction (valid/ready)
//   core_resp_*             sequencer -> core response (valid/ready)
//   acc_req_*, acc_insn_o.. sequencer -> Ara instruction, driven from the FIFO head
//   acc_resp_*, acc_result_i.. Ara -> sequencer response
//   drain_req_i/drain_done_o quiesce request (level) / all work returned
//   outstanding_o           instructions issued to Ara and not yet responded
//   perf_issued_o, perf_stall_o  (only with ARA_SEQ_PERF_CNT_EN)

module ara_acc_sequencer #(
  parameter int unsigned TRANS_ID_WIDTH  = 3,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 8,
  localparam int unsigned OutW           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  // Core request
  input  logic                      core_req_valid_i,
  output logic                      core_req_ready_o,
  input  logic [31:0]               core_insn_i,
  input  logic [63:0]               core_rs1_i,
  input  logic [63:0]               core_rs2_i,
  input  logic [1:0]                core_frm_i,
  input  logic [TRANS_ID_WIDTH-1:0] core_trans_id_i,
  // Core response
  output logic                      core_resp_valid_o,
  input  logic                      core_resp_ready_i,
  output logic [63:0]               core_resp_result_o,
  output logic [TRANS_ID_WIDTH-1:0] core_resp_trans_id_o,
  output logic                      core_resp_error_o,
  // Ara request
  output logic                      acc_req_valid_o,
  input  logic                      acc_req_ready_i,
  output logic [31:0]               acc_insn_o,
  output logic [63:0]               acc_rs1_o,
  output logic [63:0]               acc_rs2_o,
  output logic [1:0]                acc_frm_o,
  output logic [TRANS_ID_WIDTH-1:0] acc_trans_id_o,
  // Ara response
  input  logic                      acc_resp_valid_i,
  output logic                      acc_resp_ready_o,
  input  logic [63:0]               acc_result_i,
  input  logic [TRANS_ID_WIDTH-1:0] acc_trans_id_i,
  input  logic                      acc_error_i,
  // Drain handshake and status
  input  logic                      drain_req_i,
  output logic                      drain_done_o,
`ifdef ARA_SEQ_PERF_CNT_EN
  output logic [31:0]               perf_issued_o,
  output logic [31:0]               perf_stall_o,
`endif
  output logic [OutW-1:0]           outstanding_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  // FIFO entry layout, MSB first: insn | rs1 | rs2 | frm | trans_id
  localparam int unsigned EntW = 32 + 64 + 64 + 2 + TRANS_ID_WIDTH;

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic core_push;
  logic acc_issue;
  logic acc_resp_hs;
  logic core_resp_hs;

  assign core_push    = core_req_valid_i && core_req_ready_o;
  assign acc_issue    = acc_req_valid_o && acc_req_ready_i;
  assign acc_resp_hs  = acc_resp_valid_i && acc_resp_ready_o;
  assign core_resp_hs = core_resp_valid_o && core_resp_ready_i;

  // ---------------------------------------------------------------------------
  // Issue FIFO
  // ---------------------------------------------------------------------------
  // The pointers carry one extra wrap bit, so full and empty differ without a
  // separate count register.
  logic [PtrW:0]     wptr_q, wptr_d;
  logic [PtrW:0]     rptr_q, rptr_d;
  logic [PtrW:0]     fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic [EntW-1:0]   fifo_mem_q [DEPTH];
  logic [EntW-1:0]   fifo_wdata;
  logic [EntW-1:0]   fifo_head;

  assign fifo_cnt   = wptr_q - rptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PtrW + 1)'(DEPTH));
  assign fifo_wdata = {core_insn_i, core_rs1_i, core_rs2_i, core_frm_i, core_trans_id_i};

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (core_push) wptr_d = wptr_q + 1'b1;
    if (acc_issue) rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (core_push) fifo_mem_q[wptr_q[PtrW-1:0]] <= fifo_wdata;
  end

  // Masking keeps the acc_* fields at zero after reset and while idle. A push
  // never overwrites the occupied head slot, so the fields hold while stalled.
  assign fifo_head = fifo_empty ? '0 : fifo_mem_q[rptr_q[PtrW-1:0]];

  assign acc_insn_o     = fifo_head[EntW-1 -: 32];
  assign acc_rs1_o      = fifo_head[EntW-33 -: 64];
  assign acc_rs2_o      = fifo_head[EntW-97 -: 64];
  assign acc_frm_o      = fifo_head[TRANS_ID_WIDTH +: 2];
  assign acc_trans_id_o = fifo_head[TRANS_ID_WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // Outstanding counter
  // ---------------------------------------------------------------------------
  logic [OutW-1:0] out_q, out_d;
  logic            out_dec;

  // A response with nothing in flight breaks the protocol. It is ignored so the
  // counter cannot wrap below zero.
  assign out_dec = acc_resp_hs && (out_q != '0);

  always_comb begin
    out_d = out_q;
    if (acc_issue && !out_dec)      out_d = out_q + 1'b1;
    else if (!acc_issue && out_dec) out_d = out_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) out_q <= '0;
    else         out_q <= out_d;
  end

  // The cap also bounds the counter: no issue can happen at MAX_OUTSTANDING.
  assign acc_req_valid_o = !fifo_empty && (out_q < OutW'(MAX_OUTSTANDING));
  assign outstanding_o   = out_q;

  // ---------------------------------------------------------------------------
  // Response register
  // ---------------------------------------------------------------------------
  logic                      resp_full_q, resp_full_d;
  logic [63:0]               resp_result_q;
  logic [TRANS_ID_WIDTH-1:0] resp_id_q;
  logic                      resp_err_q;

  // A full register can still take a new response when the core drains it in
  // the same cycle. This sustains one response per cycle.
  assign acc_resp_ready_o = !resp_full_q || core_resp_ready_i;

  always_comb begin
    resp_full_d = resp_full_q;
    if (acc_resp_hs)       resp_full_d = 1'b1;
    else if (core_resp_hs) resp_full_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_full_q   <= 1'b0;
      resp_result_q <= '0;
      resp_id_q     <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      resp_full_q <= resp_full_d;
      if (acc_resp_hs) begin
        resp_result_q <= acc_result_i;
        resp_id_q     <= acc_trans_id_i;
        resp_err_q    <= acc_error_i;
      end
    end
  end

  assign core_resp_valid_o    = resp_full_q;
  assign core_resp_result_o   = resp_result_q;
  assign core_resp_trans_id_o = resp_id_q;
  assign core_resp_error_o    = resp_err_q;

  // ---------------------------------------------------------------------------
  // Drain state machine
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   quiesced;

  // Counts the response being taken by the core this cycle as already gone.
  // drain_done_o therefore rises the cycle after the last response is accepted.
  assign quiesced = fifo_empty && (out_q == '0) && (!resp_full_q || core_resp_ready_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StRun;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (drain_req_i) state_d = StDrain;
      end
      StDrain: begin
        if (!drain_req_i)  state_d = StRun;
        else if (quiesced) state_d = StDone;
      end
      StDone: begin
        if (!drain_req_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // The ready signal ignores any pop in the same cycle. This keeps it off the
  // Ara ready path.
  always_comb begin
    core_req_ready_o = 1'b0;
    drain_done_o     = 1'b0;
    unique case (state_q)
      StRun:   core_req_ready_o = !fifo_full;
      StDrain: core_req_ready_o = 1'b0;
      StDone:  drain_done_o     = 1'b1;
      default: core_req_ready_o = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef ARA_SEQ_PERF_CNT_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // A stall is a cycle with queued work that is held back only by the cap.
  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (acc_issue)                        perf_issued_d = perf_issued_q + 32'd1;
    if (!fifo_empty && !acc_req_valid_o)  perf_stall_d  = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued_o = perf_issued_q;
  assign perf_stall_o  = perf_stall_q;
`endif

endmodule
